// File: rtl/pipe_ctrl.sv
// Pipeline stall merge + flush/redirect sequencer with stall-cycle counters.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDOG_EN.

// One stall source: thermometer mask covering every stage at or before its stall point.
module pipe_ctrl_src #(
  parameter int STAGES = 6,
  parameter int STAGE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic [STAGES-1:0] mask
);
  always_comb begin
    mask = '0;
    for (int j = 0; j < STAGES; j++) mask[j] = req && (j <= STAGE);
  end

  a_stage_legal: assert property (@(posedge clk) disable iff (rst) (STAGE >= 1) && (STAGE < STAGES))
    else $error("pipe_ctrl: illegal REQ_STAGE entry %0d", STAGE);
endmodule

module pipe_ctrl #(
  parameter int                  STAGES       = 6,
  parameter int                  NREQ         = 4,
  parameter logic [NREQ*8-1:0]   REQ_STAGE    = {8'd4, 8'd3, 8'd2, 8'd1},
  parameter int                  FLUSH_CYCLES = 1,
  parameter int                  CNT_W        = 16,
  parameter int                  WDOG_LIMIT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq_i,
  input  logic              flush_req_i,
  input  logic [31:0]       flush_pc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_run_o,
  output logic [CNT_W-1:0]  stall_total_o,
  output logic              wdog_o
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0]       FC_M1 = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  state_t                       state;
  logic [3:0]                   cnt;
  logic [NREQ-1:0][STAGES-1:0]  masks;
  logic [STAGES-1:0]            merged;
  logic                         stalled;

  // OR of per-source thermometer masks equals the mask of the deepest request.
  for (genvar i = 0; i < NREQ; i++) begin : g_src
    localparam int RS = int'(REQ_STAGE[i*8 +: 8]);
    pipe_ctrl_src #(.STAGES(STAGES), .STAGE(RS)) u_src (
      .clk  (clk),
      .rst  (rst),
      .req  (stallreq_i[i]),
      .mask (masks[i])
    );
  end

  always_comb begin
    merged = '0;
    for (int i = 0; i < NREQ; i++) merged = merged | masks[i];
    stall_o = (rst || flush_o) ? '0 : merged;
  end

  assign stalled = |stall_o;

  // A new request while flushing restarts the window with the newest PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      flush_o  <= 1'b0;
      busy_o   <= 1'b0;
      new_pc_o <= '0;
    end else begin
      case (state)
        IDLE: if (flush_req_i) begin
          new_pc_o <= flush_pc_i;
          cnt      <= FC_M1;
          state    <= FLUSH;
          flush_o  <= 1'b1;
          busy_o   <= 1'b1;
        end
        FLUSH: if (flush_req_i) begin
          new_pc_o <= flush_pc_i;
          cnt      <= FC_M1;
        end else if (cnt == 4'd0) begin
          state   <= IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_run_o   <= '0;
      stall_total_o <= '0;
    end else if (stalled) begin
      if (stall_run_o != CMAX)   stall_run_o   <= stall_run_o + 1'b1;
      if (stall_total_o != CMAX) stall_total_o <= stall_total_o + 1'b1;
    end else begin
      stall_run_o <= '0;
    end
  end

`ifdef PIPE_CTRL_STALL_WDOG_EN
  localparam logic [31:0] WLIM = 32'(WDOG_LIMIT);
  always_ff @(posedge clk) begin
    if (rst)                             wdog_o <= 1'b0;
    else if (32'(stall_run_o) >= WLIM)   wdog_o <= 1'b1;
  end
`else
  assign wdog_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, counter/watchdog sequences, random run vs reference model.
module tb_pipe_ctrl;
  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int WL   = 5;
`ifdef PIPE_CTRL_STALL_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    stallreq_i;
  logic          flush_req_i;
  logic [31:0]   flush_pc_i;
  logic [5:0]    stall_o;
  logic          flush_o;
  logic [31:0]   new_pc_o;
  logic          busy_o;
  logic [CW-1:0] stall_run_o;
  logic [CW-1:0] stall_total_o;
  logic          wdog_o;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STAGES(6), .NREQ(4), .REQ_STAGE({8'd4, 8'd3, 8'd2, 8'd1}),
    .FLUSH_CYCLES(FC), .CNT_W(CW), .WDOG_LIMIT(WL)
  ) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .flush_req_i(flush_req_i),
    .flush_pc_i(flush_pc_i), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .busy_o(busy_o), .stall_run_o(stall_run_o), .stall_total_o(stall_total_o), .wdog_o(wdog_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: remaining flush cycles, counters as plain integers.
  int          src_stage [4] = '{1, 2, 3, 4};
  int          m_rem, m_run, m_tot;
  bit          m_wd;
  logic [31:0] m_pc;
  logic [5:0]  e_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [5:0] merge(input logic [3:0] r);
    int k = -1;
    for (int i = 0; i < 4; i++) if (r[i] && src_stage[i] > k) k = src_stage[i];
    return (k < 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
  endfunction

  // Apply inputs, then sample every output against the model (do_chk=0 only before first edge).
  task automatic drive(input logic r, input logic [3:0] q, input logic f, input logic [31:0] pc,
                       input bit do_chk);
    rst = r; stallreq_i = q; flush_req_i = f; flush_pc_i = pc;
    #1;
    e_stall = (r || m_rem > 0) ? 6'd0 : merge(q);
    if (do_chk) begin
      chk("stall_o", 32'(stall_o), 32'(e_stall));
      chk("flush_o", 32'(flush_o), 32'(m_rem > 0));
      chk("busy_o", 32'(busy_o), 32'(m_rem > 0));
      chk("new_pc_o", new_pc_o, m_pc);
      chk("stall_run_o", 32'(stall_run_o), 32'(m_run));
      chk("stall_total_o", 32'(stall_total_o), 32'(m_tot));
      chk("wdog_o", 32'(wdog_o), 32'(m_wd));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_run = 0; m_tot = 0; m_wd = 1'b0; m_pc = '0;
    end else begin
      if (WD_ON && m_run >= WL) m_wd = 1'b1;
      if (e_stall != 6'd0) begin
        m_run = (m_run < CMAX) ? m_run + 1 : CMAX;
        m_tot = (m_tot < CMAX) ? m_tot + 1 : CMAX;
      end else m_run = 0;
      if (flush_req_i) begin m_rem = FC; m_pc = flush_pc_i; end
      else if (m_rem > 0) m_rem--;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  q;
    logic        f;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [20];

  initial begin
    m_rem = 0; m_run = 0; m_tot = 0; m_wd = 1'b0; m_pc = '0; e_stall = '0;
    vt[0]  = '{1'b1, 4'hF, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 4'hF, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 4'h1, 1'b0, 32'h0,   6'b000011, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 4'h5, 1'b0, 32'h0,   6'b001111, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 4'h0, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 4'hF, 1'b1, 32'h100, 6'b011111, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 4'hF, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h100};
    vt[7]  = '{1'b0, 4'hF, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h100};
    vt[8]  = '{1'b0, 4'hF, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h100};
    vt[9]  = '{1'b0, 4'hF, 1'b0, 32'h0,   6'b011111, 1'b0, 32'h100};
    vt[10] = '{1'b0, 4'h0, 1'b1, 32'h180, 6'b000000, 1'b0, 32'h100};
    vt[11] = '{1'b0, 4'h0, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h180};
    vt[12] = '{1'b0, 4'h2, 1'b1, 32'h200, 6'b000000, 1'b1, 32'h180};
    vt[13] = '{1'b0, 4'h2, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h200};
    vt[14] = '{1'b0, 4'h2, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h200};
    vt[15] = '{1'b0, 4'h2, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h200};
    vt[16] = '{1'b0, 4'h2, 1'b0, 32'h0,   6'b000111, 1'b0, 32'h200};
    vt[17] = '{1'b0, 4'h0, 1'b1, 32'h40,  6'b000000, 1'b0, 32'h200};
    vt[18] = '{1'b1, 4'h0, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h40};
    vt[19] = '{1'b0, 4'h0, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0};

    @(negedge clk);
    drive(1'b1, 4'hF, 1'b0, 32'h0, 1'b0);
    tick();

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].q, vt[i].f, vt[i].pc, 1'b1);
      chk($sformatf("vec%0d.stall", i), 32'(stall_o), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d.flush", i), 32'(flush_o), 32'(vt[i].e_flush));
      chk($sformatf("vec%0d.pc", i), new_pc_o, vt[i].e_pc);
      tick();
    end

    // Counter saturation and run clear
    drive(1'b1, 4'h0, 1'b0, 32'h0, 1'b1); tick();
    for (int i = 0; i < 20; i++) begin drive(1'b0, 4'h1, 1'b0, 32'h0, 1'b1); tick(); end
    drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("sat.run", 32'(stall_run_o), 32'd15);
    chk("sat.total", 32'(stall_total_o), 32'd15);
    tick();
    drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("clr.run", 32'(stall_run_o), 32'd0);
    chk("clr.total", 32'(stall_total_o), 32'd15);
    tick();

    // Watchdog: 5 consecutive stalls, sticky until reset
    drive(1'b1, 4'h0, 1'b0, 32'h0, 1'b1); tick();
    for (int i = 0; i < WL; i++) begin drive(1'b0, 4'h8, 1'b0, 32'h0, 1'b1); tick(); end
    drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("wdog.set", 32'(wdog_o), 32'(WD_ON));
    tick();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1); tick(); end
    drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("wdog.sticky", 32'(wdog_o), 32'(WD_ON));
    tick();
    drive(1'b1, 4'h0, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("wdog.rst", 32'(wdog_o), 32'd0);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), $urandom, 1'b1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
